// File: rtl/pulse_gen_mc.sv
// rtl/pulse_gen_mc.sv - multi-channel programmable pulse generator
//
// Ports:
//   clk       system clock
//   rst       synchronous reset, active-high
//   start     per-channel one-cycle start trigger
//   stop      per-channel abort (wins over start)
//   high_len  per-channel high width in ticks, channel i at [i*CNT_W +: CNT_W]
//   period    per-channel full period in ticks
//   rep_cnt   per-channel pulse count, 0 = run until stop
//   inv       per-channel output inversion (only with PULSE_GEN_INV_EN defined)
//   dout      registered pulse outputs
//   busy      channel not idle
//   done      one-cycle strobe at end or abort of a train
//
// Build option: define PULSE_GEN_INV_EN to add the inv input.
module pulse_gen_mc #(
    parameter int CH_NUM   = 4,
    parameter int CNT_W    = 16,
    parameter int TICK_DIV = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [CH_NUM-1:0]       start,
    input  logic [CH_NUM-1:0]       stop,
    input  logic [CH_NUM*CNT_W-1:0] high_len,
    input  logic [CH_NUM*CNT_W-1:0] period,
    input  logic [CH_NUM*CNT_W-1:0] rep_cnt,
`ifdef PULSE_GEN_INV_EN
    input  logic [CH_NUM-1:0]       inv,
`endif
    output logic [CH_NUM-1:0]       dout,
    output logic [CH_NUM-1:0]       busy,
    output logic [CH_NUM-1:0]       done
);

    localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_HIGH, ST_LOW} state_t;

    // Shared time base; with TICK_DIV==1 the count sits at 0 and tick stays 1.
    logic [PRE_W-1:0] pre_cnt;
    logic             tick;

    assign tick = (pre_cnt == PRE_MAX);

    always_ff @(posedge clk) begin
        if (rst || tick) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + PRE_W'(1);
        end
    end

    for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
        state_t           state_q;
        logic [CNT_W-1:0] hi_q, lo_q, rem_q, cnt_q;
        logic             inv_q;
        logic             dout_q, busy_q, done_q;
        logic [CNT_W-1:0] hi_in, per_in, lo_in;
        logic             inv_in;

        assign hi_in  = high_len[i*CNT_W +: CNT_W];
        assign per_in = period[i*CNT_W +: CNT_W];
        // A period not longer than the high width still leaves a one-tick gap.
        assign lo_in  = (per_in > hi_in) ? (per_in - hi_in) : CNT_W'(1);
`ifdef PULSE_GEN_INV_EN
        assign inv_in = inv[i];
`else
        assign inv_in = 1'b0;
`endif

        always_ff @(posedge clk) begin
            if (rst) begin
                state_q <= ST_IDLE;
                hi_q    <= '0;
                lo_q    <= '0;
                rem_q   <= '0;
                cnt_q   <= '0;
                inv_q   <= 1'b0;
                dout_q  <= 1'b0;
                busy_q  <= 1'b0;
                done_q  <= 1'b0;
            end else begin
                done_q <= 1'b0;
                case (state_q)
                    ST_IDLE: begin
                        if (start[i] && !stop[i]) begin
                            hi_q  <= hi_in;
                            lo_q  <= lo_in;
                            rem_q <= rep_cnt[i*CNT_W +: CNT_W];
                            inv_q <= inv_in;
                            cnt_q <= '0;
                            if (hi_in == '0) begin
                                done_q <= 1'b1;
                            end else begin
                                state_q <= ST_HIGH;
                                dout_q  <= ~inv_in;
                                busy_q  <= 1'b1;
                            end
                        end
                    end
                    ST_HIGH: begin
                        if (stop[i]) begin
                            state_q <= ST_IDLE;
                            dout_q  <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else if (tick) begin
                            if (cnt_q == hi_q - CNT_W'(1)) begin
                                state_q <= ST_LOW;
                                cnt_q   <= '0;
                                dout_q  <= inv_q;
                            end else begin
                                cnt_q <= cnt_q + CNT_W'(1);
                            end
                        end
                    end
                    ST_LOW: begin
                        if (stop[i]) begin
                            state_q <= ST_IDLE;
                            dout_q  <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else if (tick) begin
                            if (cnt_q == lo_q - CNT_W'(1)) begin
                                cnt_q <= '0;
                                // rem_q==0 marks an endless train; a finite train
                                // leaves from rem_q==1 so it never reaches 0 here.
                                if (rem_q == CNT_W'(1)) begin
                                    state_q <= ST_IDLE;
                                    dout_q  <= 1'b0;
                                    busy_q  <= 1'b0;
                                    done_q  <= 1'b1;
                                end else begin
                                    if (rem_q != '0) begin
                                        rem_q <= rem_q - CNT_W'(1);
                                    end
                                    state_q <= ST_HIGH;
                                    dout_q  <= ~inv_q;
                                end
                            end else begin
                                cnt_q <= cnt_q + CNT_W'(1);
                            end
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        dout_q  <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end

        assign dout[i] = dout_q;
        assign busy[i] = busy_q;
        assign done[i] = done_q;
    end

endmodule

// File: tb/tb_pulse_gen_mc.sv
// tb/tb_pulse_gen_mc.sv - self-checking bench for pulse_gen_mc
module tb_pulse_gen_mc;

    localparam int CH = 4;
    localparam int W  = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [CH-1:0] start_a = '0, stop_a = '0, start_b = '0, stop_b = '0;
    logic [CH*W-1:0] hl_bus = '0, per_bus = '0, rep_bus = '0;
    logic [CH-1:0] inv_bus = '0;
    logic [CH-1:0] dout_a, busy_a, done_a, dout_b, busy_b, done_b;

    int cyc = 0;
    int vectors = 0;
    int errs = 0;

    typedef struct {
        int         dsel;
        int         ch;
        int         cyc;
        logic [2:0] val;
        string      tag;
    } exp_t;

    exp_t       sb[$];
    logic [2:0] obs_v;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pulse_gen_mc #(.CH_NUM(CH), .CNT_W(W), .TICK_DIV(1)) dut (
        .clk(clk), .rst(rst), .start(start_a), .stop(stop_a),
        .high_len(hl_bus), .period(per_bus), .rep_cnt(rep_bus),
`ifdef PULSE_GEN_INV_EN
        .inv(inv_bus),
`endif
        .dout(dout_a), .busy(busy_a), .done(done_a)
    );

    pulse_gen_mc #(.CH_NUM(CH), .CNT_W(W), .TICK_DIV(10)) dut10 (
        .clk(clk), .rst(rst), .start(start_b), .stop(stop_b),
        .high_len(hl_bus), .period(per_bus), .rep_cnt(rep_bus),
`ifdef PULSE_GEN_INV_EN
        .inv(inv_bus),
`endif
        .dout(dout_b), .busy(busy_b), .done(done_b)
    );

    function automatic logic [2:0] observe(int dsel, int ch);
        if (dsel == 0) return {dout_a[ch], busy_a[ch], done_a[ch]};
        return {dout_b[ch], busy_b[ch], done_b[ch]};
    endfunction

    // Expected {dout,busy,done} for cycles c0..c1 of one channel.
    task automatic exp_rng(input int dsel, input int ch, input int c0, input int c1,
                           input logic [2:0] val, input string tag);
        exp_t e;
        for (int c = c0; c <= c1; c++) begin
            e.dsel = dsel; e.ch = ch; e.cyc = c; e.val = val; e.tag = tag;
            sb.push_back(e);
        end
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_cfg(input int ch, input int hl, input int per, input int rep);
        hl_bus[ch*W +: W]  = W'(hl);
        per_bus[ch*W +: W] = W'(per);
        rep_bus[ch*W +: W] = W'(rep);
    endtask

    always @(negedge clk) begin
        for (int k = sb.size() - 1; k >= 0; k--) begin
            if (sb[k].cyc == cyc) begin
                obs_v = observe(sb[k].dsel, sb[k].ch);
                vectors++;
                assert (obs_v === sb[k].val) else begin
                    errs++;
                    $error("FAIL %s dut%0d ch%0d cyc%0d: dout/busy/done observed %b expected %b",
                           sb[k].tag, sb[k].dsel, sb[k].ch, cyc, obs_v, sb[k].val);
                end
                sb.delete(k);
            end
        end
    end

    initial begin
        for (int c = 0; c < CH; c++) begin
            exp_rng(0, c, 1, 2, 3'b000, "reset");
            exp_rng(1, c, 1, 2, 3'b000, "reset10");
        end
        wait_cyc(3);
        rst = 1'b0;

        // Basic train: high 3, period 5, two pulses; later start and config changes ignored.
        wait_cyc(9);
        exp_rng(0, 0, 10, 10, 3'b000, "t1_pre");
        exp_rng(0, 0, 11, 13, 3'b110, "t1_hi1");
        exp_rng(0, 0, 14, 15, 3'b010, "t1_lo1");
        exp_rng(0, 0, 16, 18, 3'b110, "t1_hi2");
        exp_rng(0, 0, 19, 20, 3'b010, "t1_lo2");
        exp_rng(0, 0, 21, 21, 3'b001, "t1_done");
        exp_rng(0, 0, 22, 22, 3'b000, "t1_idle");
        wait_cyc(10);
        set_cfg(0, 3, 5, 2);
        start_a = 4'b0001;
        wait_cyc(11);
        start_a = '0;
        set_cfg(0, 9, 9, 9);
        wait_cyc(12);
        set_cfg(0, 1, 1, 1);
        start_a = 4'b0001;
        wait_cyc(13);
        start_a = '0;

        // period <= high, zero high width, start+stop together in idle.
        wait_cyc(30);
        exp_rng(0, 1, 31, 34, 3'b110, "t2_hi");
        exp_rng(0, 1, 35, 35, 3'b010, "t2_gap");
        exp_rng(0, 1, 36, 36, 3'b001, "t2_done");
        exp_rng(0, 1, 37, 37, 3'b000, "t2_idle");
        exp_rng(0, 2, 31, 31, 3'b001, "t2_zero_done");
        exp_rng(0, 2, 32, 33, 3'b000, "t2_zero_idle");
        exp_rng(0, 3, 31, 33, 3'b000, "t2_startstop");
        set_cfg(1, 4, 2, 1);
        set_cfg(2, 0, 7, 3);
        set_cfg(3, 2, 4, 1);
        start_a = 4'b1110;
        stop_a  = 4'b1000;
        wait_cyc(31);
        start_a = '0;
        stop_a  = '0;

        // Endless train aborted in the 3rd pulse, restarted the following cycle.
        wait_cyc(50);
        exp_rng(0, 0, 51, 52, 3'b110, "t3_hi1");
        exp_rng(0, 0, 53, 54, 3'b010, "t3_lo1");
        exp_rng(0, 0, 55, 56, 3'b110, "t3_hi2");
        exp_rng(0, 0, 57, 58, 3'b010, "t3_lo2");
        exp_rng(0, 0, 59, 59, 3'b110, "t3_hi3");
        exp_rng(0, 0, 60, 60, 3'b001, "t3_abort");
        exp_rng(0, 0, 61, 61, 3'b110, "t3_restart");
        exp_rng(0, 0, 62, 62, 3'b010, "t3_rlo");
        exp_rng(0, 0, 63, 63, 3'b001, "t3_rdone");
        exp_rng(0, 0, 64, 64, 3'b000, "t3_ridle");
        set_cfg(0, 2, 4, 0);
        start_a = 4'b0001;
        wait_cyc(51);
        start_a = '0;
        wait_cyc(59);
        stop_a = 4'b0001;
        wait_cyc(60);
        stop_a = '0;
        set_cfg(0, 1, 2, 1);
        start_a = 4'b0001;
        wait_cyc(61);
        start_a = '0;

        // Reset in the middle of LOW: everything clears, no done strobe.
        wait_cyc(80);
        exp_rng(0, 0, 81, 82, 3'b110, "t4_hi");
        exp_rng(0, 0, 83, 84, 3'b010, "t4_lo");
        exp_rng(0, 0, 85, 88, 3'b000, "t4_rst");
        exp_rng(0, 1, 85, 85, 3'b000, "t4_rst_ch1");
        set_cfg(0, 2, 6, 3);
        start_a = 4'b0001;
        wait_cyc(81);
        start_a = '0;
        wait_cyc(84);
        rst = 1'b1;
        wait_cyc(85);
        rst = 1'b0;

        // TICK_DIV=10: prescaler restarted by the reset above, ticks at 94,104,114,...
        wait_cyc(99);
        for (int c = 0; c < 3; c++) begin
            exp_rng(1, c, 100, 100, 3'b000, "t5_pre");
            exp_rng(1, c, 101, 114, 3'b110, "t5_hi");
            exp_rng(1, c, 115, 134, 3'b010, "t5_lo");
            exp_rng(1, c, 135, 135, 3'b001, "t5_done");
            exp_rng(1, c, 136, 137, 3'b000, "t5_idle");
        end
        exp_rng(1, 3, 101, 124, 3'b110, "t5_hi_ch3");
        exp_rng(1, 3, 125, 134, 3'b010, "t5_lo_ch3");
        exp_rng(1, 3, 135, 135, 3'b001, "t5_done_ch3");
        exp_rng(1, 3, 136, 137, 3'b000, "t5_idle_ch3");
        wait_cyc(100);
        set_cfg(0, 2, 4, 1);
        set_cfg(1, 2, 4, 1);
        set_cfg(2, 2, 4, 1);
        set_cfg(3, 3, 3, 1);
        start_b = 4'b1111;
        wait_cyc(101);
        start_b = '0;

`ifdef PULSE_GEN_INV_EN
        // Inverted channel: low while HIGH, high while LOW, 0 after done.
        wait_cyc(149);
        exp_rng(0, 2, 151, 152, 3'b010, "t6_inv_hi");
        exp_rng(0, 2, 153, 153, 3'b110, "t6_inv_lo");
        exp_rng(0, 2, 154, 154, 3'b001, "t6_inv_done");
        exp_rng(0, 2, 155, 156, 3'b000, "t6_inv_idle");
        wait_cyc(150);
        set_cfg(2, 2, 3, 1);
        inv_bus = 4'b0100;
        start_a = 4'b0100;
        wait_cyc(151);
        start_a = '0;
        inv_bus = '0;
`endif

        wait_cyc(170);
        vectors++;
        assert (sb.size() === 0) else begin
            errs++;
            $error("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
